// File: rtl/axi4l_regfile_sequencer.sv
// AXI4-Lite master that writes a seed-derived pattern to num_words registers,
// reads every word back, and records the index of the first failing transaction.
module axi4l_regfile_sequencer #(
  parameter int unsigned           data_width = 32,
  parameter int unsigned           addr_width = 5,
  parameter int unsigned           num_words  = 32,
  parameter logic [data_width-1:0] seed       = data_width'('hA5A50000)
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [addr_width-1:0]   err_addr,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [addr_width-1:0]   AWADDR,
  output logic [2:0]              AWPROT,
  output logic                    WVALID,
  input  logic                    WREADY,
  output logic [data_width-1:0]   WDATA,
  output logic [data_width/8-1:0] WSTRB,
  input  logic                    BVALID,
  output logic                    BREADY,
  input  logic [1:0]              BRESP,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  output logic [addr_width-1:0]   ARADDR,
  output logic [2:0]              ARPROT,
  input  logic                    RVALID,
  output logic                    RREADY,
  input  logic [data_width-1:0]   RDATA,
  input  logic [1:0]              RRESP
);

  // One extra index bit so num_words = 2**addr_width reaches its last word cleanly.
  localparam int unsigned      IDX_W    = addr_width + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_words - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  state_t                state_q,    state_d;
  logic [IDX_W-1:0]      idx_q,      idx_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic                  error_q,    error_d;
  logic [addr_width-1:0] err_addr_q, err_addr_d;
  logic                  awvalid_q,  awvalid_d;
  logic                  wvalid_q,   wvalid_d;
  logic                  bready_q,   bready_d;
  logic                  arvalid_q,  arvalid_d;
  logic                  rready_q,   rready_d;
  logic [addr_width-1:0] awaddr_q,   awaddr_d;
  logic [addr_width-1:0] araddr_q,   araddr_d;
  logic [data_width-1:0] wdata_q,    wdata_d;
  logic                  fail;

  function automatic logic [data_width-1:0] pattern(input logic [IDX_W-1:0] i);
    return seed ^ data_width'(i);
  endfunction

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    wdata_d    = wdata_q;
    fail       = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_AW;
          idx_d      = '0;
          error_d    = 1'b0;
          err_addr_d = '0;
        end
      end
      S_AW: if (awvalid_q && AWREADY) state_d = S_W;
      S_W:  if (wvalid_q && WREADY)   state_d = S_B;
      S_B: begin
        if (BVALID && bready_q) begin
          fail = (BRESP != 2'b00);
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_AR;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_AW;
          end
        end
      end
      S_AR: if (arvalid_q && ARREADY) state_d = S_R;
      S_R: begin
        if (RVALID && rready_q) begin
          fail = (RRESP != 2'b00) || (RDATA != pattern(idx_q));
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_AR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Failures never abort; only the first one of a run records its index.
    if (fail) begin
      error_d = 1'b1;
      if (!error_q) err_addr_d = idx_q[addr_width-1:0];
    end

    // Outputs are registered, so they are decoded from the state being entered.
    awvalid_d = (state_d == S_AW);
    wvalid_d  = (state_d == S_W);
    bready_d  = (state_d == S_B);
    arvalid_d = (state_d == S_AR);
    rready_d  = (state_d == S_R);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    if (state_d == S_AW) awaddr_d = idx_d[addr_width-1:0];
    if (state_d == S_W)  wdata_d  = pattern(idx_d);
    if (state_d == S_AR) araddr_d = idx_d[addr_width-1:0];
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values, whatever the block order.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_addr = err_addr_q;
  assign AWVALID  = awvalid_q;
  assign AWADDR   = awaddr_q;
  assign AWPROT   = 3'b000;
  assign WVALID   = wvalid_q;
  assign WDATA    = wdata_q;
  assign WSTRB    = '1;
  assign BREADY   = bready_q;
  assign ARVALID  = arvalid_q;
  assign ARADDR   = araddr_q;
  assign ARPROT   = 3'b000;
  assign RREADY   = rready_q;

endmodule
